// File: rtl/branch_update_queue.sv
// Branch update queue: in-order tracking of BHT-predicted branches from fetch
// until execute resolves them. Emits the BHT training strobe and a one-cycle
// flush with redirect PC on a misprediction.
module branch_update_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = 8,
   parameter int unsigned PC_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [IDX_W-1:0]         push_index,
   input  logic                     push_pred_taken,
   input  logic [PC_W-1:0]          push_pc,
   input  logic [PC_W-1:0]          push_pred_target,
   input  logic                     res_valid,
   input  logic                     res_taken,
   input  logic [PC_W-1:0]          res_target,
   output logic                     update_en,
   output logic [IDX_W-1:0]         update_index,
   output logic                     update_taken,
   output logic                     flush,
   output logic [PC_W-1:0]          redirect_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     res_underflow
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Full = CntW'(DEPTH);

   // Entry storage; contents need no reset since count qualifies them.
   logic [IDX_W-1:0] idx_mem  [DEPTH];
   logic             pt_mem   [DEPTH];
   logic [PC_W-1:0]  pc_mem   [DEPTH];
   logic [PC_W-1:0]  tgt_mem  [DEPTH];

   logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             upd_en_q, upd_en_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic             upd_tk_q, upd_tk_d;
   logic             flush_q, flush_d;
   logic [PC_W-1:0]  redir_q, redir_d;
   logic             unf_q, unf_d;

   logic             push_acc, res_acc, mispredict, mem_we;
   logic [IDX_W-1:0] head_idx;
   logic             head_pt;
   logic [PC_W-1:0]  head_pc, head_tgt;

   assign head_idx = idx_mem[rd_q];
   assign head_pt  = pt_mem[rd_q];
   assign head_pc  = pc_mem[rd_q];
   assign head_tgt = tgt_mem[rd_q];

   // Ready deliberately ignores a same-cycle pop so a full queue never takes a push.
   assign push_ready = (count_q < Full) && !flush_q;
   assign push_acc   = push_valid && push_ready;
   assign res_acc    = res_valid && (count_q != '0) && !flush_q;
   assign mispredict = (res_taken != head_pt) ||
                       (res_taken && head_pt && (res_target != head_tgt));
   // A push in the mispredict cycle is wrong-path and is dropped.
   assign mem_we     = push_acc && !(res_acc && mispredict);

   // Next-state: pointers, occupancy and registered update/flush outputs.
   always_comb begin
      wr_d      = wr_q;
      rd_d      = rd_q;
      count_d   = count_q;
      upd_en_d  = 1'b0;
      upd_idx_d = upd_idx_q;
      upd_tk_d  = upd_tk_q;
      flush_d   = 1'b0;
      redir_d   = redir_q;
      unf_d     = res_valid && (count_q == '0) && !flush_q;
      if (res_acc) begin
         upd_en_d  = 1'b1;
         upd_idx_d = head_idx;
         upd_tk_d  = res_taken;
      end
      if (res_acc && mispredict) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
         flush_d = 1'b1;
         redir_d = res_taken ? res_target : head_pc + PC_W'(4);
      end else begin
         if (push_acc) wr_d = wr_q + PtrW'(1);
         if (res_acc)  rd_d = rd_q + PtrW'(1);
         if (push_acc && !res_acc)      count_d = count_q + CntW'(1);
         else if (!push_acc && res_acc) count_d = count_q - CntW'(1);
      end
   end

   // State register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q      <= '0;
         rd_q      <= '0;
         count_q   <= '0;
         upd_en_q  <= 1'b0;
         upd_idx_q <= '0;
         upd_tk_q  <= 1'b0;
         flush_q   <= 1'b0;
         redir_q   <= '0;
         unf_q     <= 1'b0;
      end else begin
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         count_q   <= count_d;
         upd_en_q  <= upd_en_d;
         upd_idx_q <= upd_idx_d;
         upd_tk_q  <= upd_tk_d;
         flush_q   <= flush_d;
         redir_q   <= redir_d;
         unf_q     <= unf_d;
      end
   end

   // Entry write on an accepted, non-dropped push.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         idx_mem[wr_q] <= push_index;
         pt_mem[wr_q]  <= push_pred_taken;
         pc_mem[wr_q]  <= push_pc;
         tgt_mem[wr_q] <= push_pred_target;
      end
   end

   assign update_en     = upd_en_q;
   assign update_index  = upd_idx_q;
   assign update_taken  = upd_tk_q;
   assign flush         = flush_q;
   assign redirect_pc   = redir_q;
   assign count         = count_q;
   assign res_underflow = unf_q;

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

Tracks every branch the fetch stage predicts with the 2-bit BHT until the execute stage resolves it. Emits the one-cycle BHT training strobe (index + actual direction) and a pipeline flush with redirect PC on misprediction. Sits between fetch (push side), execute (resolve side) and the BHT update port. It is the writer side of the predictor's update interface. In-order FIFO: branches resolve oldest-first.

## Interface
- DEPTH, 4: in-flight branch capacity; power of two, ≥2
- IDX_W, 8: BHT index width
- PC_W, 32: PC width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; state clears while 0
- push_valid  in  1  fetch predicted a branch this cycle
- push_ready  out  1  entry accepted when push_valid && push_ready
- push_index  in  IDX_W  BHT index used for the prediction
- push_pred_taken  in  1  predicted direction (BHT counter MSB)
- push_pc  in  PC_W  branch PC
- push_pred_target  in  PC_W  predicted target; meaningful only if push_pred_taken
- res_valid  in  1  execute resolved the oldest outstanding branch
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual taken target
- update_en  out  1  BHT training strobe, one cycle per accepted resolution
- update_index  out  IDX_W  index to train
- update_taken  out  1  actual direction to train
- flush  out  1  one-cycle mispredict pulse
- redirect_pc  out  PC_W  correct fetch PC, valid when flush=1
- count  out  $clog2(DEPTH)+1  entries held
- res_underflow  out  1  one-cycle pulse: res_valid arrived with queue empty

## Operation
- Storage: DEPTH entries of {index, pred_taken, pc, pred_target}; read/write pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- push_ready = (count < DEPTH) && !flush. A push accepted only when push_valid && push_ready.
- Resolution accepted when res_valid && count ≠ 0 && !flush; it pops the head entry.
- res_valid with count=0 and !flush: no pop, no update; res_underflow=1 next cycle.
- res_valid while flush=1: ignored silently (wrong-path).
- Mispredict = (res_taken ≠ pred_taken) || (res_taken && pred_taken && res_target ≠ pred_target).
- redirect_pc = res_target if res_taken, else head.pc + 4 (PC_W wrap-around arithmetic).
- On an accepted resolution, every cycle: update_en=1, update_index=head.index, update_taken=res_taken (direction-only; target mismatch still trains with the actual direction).
- On mispredict: the queue is emptied at the same edge (count→0, pointers reset). Any push in that same cycle is dropped. flush=1 for the following cycle.
- Simultaneous accepted push and non-mispredict resolve: both occur; count unchanged. This is legal even at count=DEPTH only if push_ready was 1, i.e. never when full (push_ready ignores the same-cycle pop).
- Push and resolve in the same cycle with count=0: push accepted, resolve is underflow (a branch is not resolvable in its push cycle).

## Timing
- All outputs except push_ready are registered; latency resolve→update_en/flush/redirect_pc = 1 cycle.
- push_ready is combinational from count and flush.
- Reset values: update_en=0, update_index=0, update_taken=0, flush=0, redirect_pc=0, res_underflow=0, count=0, push_ready=1 after reset release.
- update_en, flush and res_underflow are single-cycle pulses. They go low the cycle after unless another accepted event occurs.
- Reset asserted mid-operation: queue emptied and all outputs take reset values immediately (asynchronous), independent of clk.

## Test plan
- Reset, push idx=0x12 pred_taken=1 pc=0x100 target=0x200, resolve taken target=0x200 -> next cycle update_en=1, update_index=0x12, update_taken=1, flush=0, count=0.
- Push idx=0x05 pred_taken=0 pc=0x3FC, resolve taken target=0x40 -> update_taken=1, flush=1, redirect_pc=0x40; push in the resolve cycle dropped, count=0.
- Push pred_taken=1 pc=0xFFFFFFFC, resolve not-taken -> flush=1, redirect_pc=0x00000000 (wrap); target mismatch with both taken (pred 0x200, actual 0x204) -> flush=1, redirect_pc=0x204, update_taken=1.
- Push 4 entries (DEPTH=4) -> push_ready=0, 5th push dropped; resolve 4 correctly in order -> update_index sequence matches push order, count returns 0, pointers wrap correctly on 4 more pushes.
- res_valid on empty queue -> res_underflow=1 one cycle, update_en=0; res_valid during flush cycle -> no update, no underflow.
- Fill 3 entries, drop reset low between clocks -> count=0, flush=0, update_en=0 immediately; after release push_ready=1 and first push/resolve behaves normally.
